// File: rtl/iterative_popcount_if.sv
// rtl/iterative_popcount_if.sv - word-in / count-out val/rdy bundle for iterative_popcount
// ITER_POPCOUNT_ZEROS_EN adds the mode signal that travels with the input word.
interface iterative_popcount_if #(
   parameter int NBITS = 100
);
   localparam int CNT_W = $clog2(NBITS + 1);

   logic             in_val;
   logic             in_rdy;
   logic [NBITS-1:0] in_;
   logic             out_val;
   logic             out_rdy;
   logic [CNT_W-1:0] out;
`ifdef ITER_POPCOUNT_ZEROS_EN
   logic             mode;

   modport master (
      output in_val, in_, mode, out_rdy,
      input  in_rdy, out_val, out
   );
   modport slave (
      input  in_val, in_, mode, out_rdy,
      output in_rdy, out_val, out
   );
`else
   modport master (
      output in_val, in_, out_rdy,
      input  in_rdy, out_val, out
   );
   modport slave (
      input  in_val, in_, out_rdy,
      output in_rdy, out_val, out
   );
`endif
endinterface

// File: rtl/iterative_popcount.sv
// rtl/iterative_popcount.sv - multi-cycle popcount, CHUNK bits per cycle, val/rdy in and out
// ITER_POPCOUNT_ZEROS_EN enables counting zero bits of the real NBITS via bus.mode.
module iterative_popcount #(
   parameter int NBITS = 100,
   parameter int CHUNK = 8
) (
   input logic                 clk,
   input logic                 reset,
   iterative_popcount_if.slave bus
);
   localparam int N_ITER = (NBITS + CHUNK - 1) / CHUNK;
   localparam int WORK_W = CHUNK * N_ITER;
   localparam int CNT_W  = $clog2(NBITS + 1);
   localparam int ITER_W = $clog2(N_ITER + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state_q;
   logic [WORK_W-1:0] work_q;
   logic [CNT_W-1:0]  acc_q;
   logic [CNT_W-1:0]  acc_d;
   logic [CNT_W-1:0]  chunk_pc;
   logic [CNT_W-1:0]  result_d;
   logic [CNT_W-1:0]  out_q;
   logic [ITER_W-1:0] iter_q;
   logic              in_rdy_q;
   logic              out_val_q;
`ifdef ITER_POPCOUNT_ZEROS_EN
   logic              mode_q;
`endif

   always_comb begin
      chunk_pc = '0;
      for (int i = 0; i < CHUNK; i++) begin
         chunk_pc = chunk_pc + CNT_W'(work_q[i]);
      end
      acc_d = acc_q + chunk_pc;
`ifdef ITER_POPCOUNT_ZEROS_EN
      // Zeros are derived from the final ones count so pad bits never contribute.
      result_d = mode_q ? (CNT_W'(NBITS) - acc_d) : acc_d;
`else
      result_d = acc_d;
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         work_q    <= '0;
         acc_q     <= '0;
         iter_q    <= '0;
         in_rdy_q  <= 1'b0;
         out_val_q <= 1'b0;
         out_q     <= '0;
`ifdef ITER_POPCOUNT_ZEROS_EN
         mode_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               // in_rdy is held low through reset and rises on the first released edge.
               in_rdy_q <= 1'b1;
               if (in_rdy_q && bus.in_val) begin
                  work_q   <= WORK_W'(bus.in_);
                  acc_q    <= '0;
                  iter_q   <= '0;
                  in_rdy_q <= 1'b0;
                  state_q  <= CALC;
`ifdef ITER_POPCOUNT_ZEROS_EN
                  mode_q   <= bus.mode;
`endif
               end
            end
            CALC: begin
               acc_q  <= acc_d;
               work_q <= work_q >> CHUNK;
               iter_q <= iter_q + ITER_W'(1);
               if (iter_q == ITER_W'(N_ITER - 1)) begin
                  state_q   <= DONE;
                  out_val_q <= 1'b1;
                  out_q     <= result_d;
               end
            end
            DONE: begin
               if (bus.out_rdy) begin
                  state_q   <= IDLE;
                  out_val_q <= 1'b0;
                  out_q     <= '0;
                  in_rdy_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_rdy  = in_rdy_q;
   assign bus.out_val = out_val_q;
   assign bus.out     = out_q;
endmodule

// File: tb/tb_iterative_popcount.sv
// tb/tb_iterative_popcount.sv - self-checking bench over three iterative_popcount configurations
// Build with ITER_POPCOUNT_ZEROS_EN defined to also cover zero counting.
module tb_iterative_popcount;
   logic        clk = 1'b0;
   logic        reset;
   logic        in_val;
   logic        out_rdy;
   logic [99:0] in_word;
`ifdef ITER_POPCOUNT_ZEROS_EN
   logic        mode;
`endif
   int          sel;
   logic        cur_in_rdy;
   logic        cur_out_val;
   logic [6:0]  cur_out;
   int          checks = 0;
   int          failures = 0;
   int          niter [3] = '{13, 1, 4};
   int          nbits [3] = '{100, 100, 13};

   typedef struct {
      int          s;
      logic [99:0] w;
      bit          m;
      int          hold;
      int          exp_out;
      string       name;
   } vec_t;
   vec_t vecs [7];

   always #5 clk = ~clk;

   iterative_popcount_if #(.NBITS(100)) if0 ();
   iterative_popcount_if #(.NBITS(100)) if1 ();
   iterative_popcount_if #(.NBITS(13))  if2 ();

   assign if0.in_val  = in_val && (sel == 0);
   assign if1.in_val  = in_val && (sel == 1);
   assign if2.in_val  = in_val && (sel == 2);
   assign if0.in_     = in_word;
   assign if1.in_     = in_word;
   assign if2.in_     = in_word[12:0];
   assign if0.out_rdy = out_rdy;
   assign if1.out_rdy = out_rdy;
   assign if2.out_rdy = out_rdy;
`ifdef ITER_POPCOUNT_ZEROS_EN
   assign if0.mode = mode;
   assign if1.mode = mode;
   assign if2.mode = mode;
`endif

   iterative_popcount #(.NBITS(100), .CHUNK(8))   dut0 (.clk(clk), .reset(reset), .bus(if0));
   iterative_popcount #(.NBITS(100), .CHUNK(100)) dut1 (.clk(clk), .reset(reset), .bus(if1));
   iterative_popcount #(.NBITS(13),  .CHUNK(4))   dut2 (.clk(clk), .reset(reset), .bus(if2));

   always_comb begin
      cur_in_rdy  = if0.in_rdy;
      cur_out_val = if0.out_val;
      cur_out     = if0.out;
      case (sel)
         1: begin
            cur_in_rdy  = if1.in_rdy;
            cur_out_val = if1.out_val;
            cur_out     = if1.out;
         end
         2: begin
            cur_in_rdy  = if2.in_rdy;
            cur_out_val = if2.out_val;
            cur_out     = 7'(if2.out);
         end
         default: ;
      endcase
   end

   function automatic int ref_pop(input logic [99:0] w, input int n, input bit m);
      int c = 0;
      for (int i = 0; i < n; i++) if (w[i]) c++;
      return m ? (n - c) : c;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic do_word(input int s, input logic [99:0] w, input bit m, input int hold,
                          input int exp_out, input string name);
      int          k;
      logic [127:0] junk;
      sel = s;
      @(negedge clk);
      k = 0;
      while (!cur_in_rdy && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk({name, " in_rdy before accept"}, 32'(cur_in_rdy), 32'd1);
      in_val  = 1'b1;
      in_word = w;
`ifdef ITER_POPCOUNT_ZEROS_EN
      mode    = m;
`endif
      @(negedge clk);
      in_val  = 1'b0;
      junk    = {$urandom, $urandom, $urandom, $urandom};
      in_word = junk[99:0];
`ifdef ITER_POPCOUNT_ZEROS_EN
      mode    = ~m;
`endif
      out_rdy = (hold == 0);
      k = 0;
      while (!cur_out_val && k < 64) begin
         chk({name, " in_rdy busy"}, 32'(cur_in_rdy), 32'd0);
         chk({name, " out zero while busy"}, 32'(cur_out), 32'd0);
         @(negedge clk);
         k++;
      end
      chk({name, " latency"}, 32'(k), 32'(niter[s]));
      for (int h = 0; h < hold; h++) begin
         chk({name, " hold out_val"}, 32'(cur_out_val), 32'd1);
         chk({name, " hold out"}, 32'(cur_out), 32'(exp_out));
         chk({name, " hold in_rdy"}, 32'(cur_in_rdy), 32'd0);
         @(negedge clk);
      end
      chk({name, " out"}, 32'(cur_out), 32'(exp_out));
      chk({name, " out_val"}, 32'(cur_out_val), 32'd1);
      out_rdy = 1'b1;
      @(negedge clk);
      chk({name, " out_val after xfer"}, 32'(cur_out_val), 32'd0);
      chk({name, " in_rdy after xfer"}, 32'(cur_in_rdy), 32'd1);
      @(negedge clk);
      chk({name, " single xfer"}, 32'(cur_out_val), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] r1;
      logic [127:0] r2;
      logic [99:0]  w;
      bit           m;
      int           seen;

      vecs[0] = '{0, 100'h0, 1'b0, 0, 0, "zero"};
      vecs[1] = '{0, 100'hf_ffff_ffff_ffff_ffff_ffff_ffff, 1'b0, 0, 100, "all_ones"};
      vecs[2] = '{0, 100'h3_3333_3333_3333_3333_3333_3333, 1'b0, 0, 50, "pattern_33"};
      vecs[3] = '{0, 100'h1, 1'b0, 0, 1, "single_one"};
      vecs[4] = '{0, 100'hf_ffff_ffff_ffff_ffff_ffff_ffff, 1'b0, 5, 100, "backpressure"};
      vecs[5] = '{2, 100'h1fff, 1'b0, 0, 13, "n13_ones"};
      vecs[6] = '{1, 100'hf_ffff_ffff_ffff_ffff_ffff_ffff, 1'b0, 0, 100, "chunk_eq_nbits"};

      sel     = 0;
      reset   = 1'b0;
      in_val  = 1'b0;
      out_rdy = 1'b1;
      in_word = '0;
`ifdef ITER_POPCOUNT_ZEROS_EN
      mode    = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("reset in_rdy", 32'(cur_in_rdy), 32'd0);
      chk("reset out_val", 32'(cur_out_val), 32'd0);
      chk("reset out", 32'(cur_out), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("in_rdy after reset", 32'(cur_in_rdy), 32'd1);
      repeat (4) @(negedge clk);
      chk("idle stays ready", 32'(cur_in_rdy), 32'd1);
      chk("idle no out_val", 32'(cur_out_val), 32'd0);

      for (int i = 0; i < 7; i++) begin
         do_word(vecs[i].s, vecs[i].w, vecs[i].m, vecs[i].hold, vecs[i].exp_out, vecs[i].name);
      end

      // Reset during the sixth CALC cycle must discard the word.
      sel     = 0;
      out_rdy = 1'b1;
      @(negedge clk);
      in_val  = 1'b1;
      in_word = 100'hf_ffff_ffff_ffff_ffff_ffff_ffff;
      @(negedge clk);
      in_val  = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("abort in_rdy low", 32'(cur_in_rdy), 32'd0);
      chk("abort out_val low", 32'(cur_out_val), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("abort in_rdy back", 32'(cur_in_rdy), 32'd1);
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         if (cur_out_val) seen++;
         @(negedge clk);
      end
      chk("abort no out_val", 32'(seen), 32'd0);
      do_word(0, 100'hff, 1'b0, 0, 8, "after_abort");

`ifdef ITER_POPCOUNT_ZEROS_EN
      do_word(0, 100'h1, 1'b1, 0, 99, "zeros_one");
      do_word(0, 100'hf_ffff_ffff_ffff_ffff_ffff_ffff, 1'b1, 0, 0, "zeros_all_ones");
      do_word(2, 100'h0, 1'b1, 0, 13, "zeros_n13");
`endif

      for (int s = 0; s < 3; s++) begin
         for (int n = 0; n < 20; n++) begin
            r1 = {$urandom, $urandom, $urandom, $urandom};
            r2 = {$urandom, $urandom, $urandom, $urandom};
            case ($urandom_range(0, 3))
               0: w = r1[99:0] & r2[99:0];
               1: w = r1[99:0] | r2[99:0];
               default: w = r1[99:0];
            endcase
            m = 1'b0;
`ifdef ITER_POPCOUNT_ZEROS_EN
            m = 1'($urandom_range(0, 1));
`endif
            do_word(s, w, m, $urandom_range(0, 2), ref_pop(w, nbits[s], m), $sformatf("rand_s%0d_%0d", s, n));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/iterative_popcount.md
# iterative_popcount

- Parametrised, multi-cycle population counter with val/rdy handshakes on both input and output.
- Captures an `NBITS`-wide word and counts its one bits, `CHUNK` bits per cycle, into an accumulator.
- Returns the count on a latency-insensitive output interface.
- Successor to the single-cycle 100-bit combinational popcount: it trades latency for area on wide words, and it sits in front of arithmetic/statistics units that consume counts at a lower rate than words arrive.

## Interface
- `NBITS`, default 100: input word width; legal range ≥ 1.
- `CHUNK`, default 8: bits counted per cycle; legal range 1 ≤ `CHUNK` ≤ `NBITS`.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-low reset (asserted when 0, sampled on the rising edge of `clk`).
- `in_val`  input  1  input word valid.
- `in_rdy`  output  1  block can accept a word.
- `in_`  input  `NBITS`  word to count.
- `out_val`  output  1  count valid.
- `out_rdy`  input  1  consumer accepts the count.
- `out`  output  `$clog2(NBITS+1)`  population count; 7 bits at default.
- `mode`  input  1  present only with `ITER_POPCOUNT_ZEROS_EN` (see Configuration).

## Operation
- `N_ITER = ceil(NBITS/CHUNK)`; 13 at default.
- The working register is `CHUNK*N_ITER` bits wide; the upper pad bits are zero-filled on load.
- The accumulator is `$clog2(NBITS+1)` bits wide and never overflows by construction.
- States:
  - IDLE: `in_rdy=1`. When `in_val` is high, capture `in_` into the working register, clear the accumulator, clear the iteration counter, and go to CALC.
  - CALC: each cycle, add the popcount of the low `CHUNK` bits, shift the register right by `CHUNK`, and increment the iteration counter. After the `N_ITER`-th add, go to DONE.
  - DONE: `out_val=1` and `out` equals the accumulator. On `out_val && out_rdy`, go to IDLE.
- `in_rdy` is 0 in CALC and DONE. There is no overlap between words; throughput is one word per `N_ITER+2` cycles at best.
- While `out_val=1`, `out` is held stable regardless of `in_val` or `in_`.
- `in_` is sampled only on the accepting edge. Changes to `in_` after acceptance have no effect.
- `out` reads 0 in IDLE and CALC. It is valid only in DONE.

## Timing
- Reset: while `reset=0` at an edge, the block goes to IDLE with the accumulator cleared.
  - Outputs after that edge: `in_rdy=0` while `reset` is held low, `out_val=0`, `out=0`.
  - `in_rdy` rises in the first cycle after `reset` returns to 1.
- Reset mid-operation (in CALC or DONE) aborts the word with no output. A pending DONE result is discarded.
- Accept at edge E (`in_val && in_rdy`): CALC occupies the cycles after edges E..E+`N_ITER`-1, and `out_val` rises after edge E+`N_ITER`.
  - Latency from accepting edge to `out_val` is `N_ITER` cycles: 13 at default, 1 when `CHUNK=NBITS`.
- Output transfer at edge F: `out_val=0` and `in_rdy=1` after edge F. The earliest next accept is edge F+1.
- `out_rdy` may be high before `out_val`. This causes no effect and adds no extra cycle.
- `in_val` deasserted in IDLE: the block stays in IDLE and its state does not change.

## Configuration
- `ITER_POPCOUNT_ZEROS_EN` defined:
  - Adds the `mode` input, sampled together with `in_` at the accepting edge.
  - `mode=0`: count ones.
  - `mode=1`: count zero bits of the `NBITS` real bits. The result is `NBITS - ones`, computed on entry to DONE, so pad bits are never counted.
  - Latency is unchanged.
- Not defined: no `mode` port; the block always counts ones.

## Test plan
- Default params, `in_=0`, `out_rdy=1` -> `out_val` rises 13 cycles after accept, `out=0`; `in_rdy=1` the cycle after transfer.
- Default params, `in_=100'hf_ffff_ffff_ffff_ffff_ffff_ffff` -> `out=100`; `in_=100'h3_3333_3333_3333_3333_3333_3333` -> `out=50`; `in_=1` -> `out=1`.
- Backpressure: hold `out_rdy=0` for 5 cycles after `out_val` -> `out_val=1`, `out` stable, and `in_rdy=0` throughout. Raising `out_rdy` gives exactly one transfer.
- Assert `reset=0` for one edge during cycle 6 of CALC -> `out_val` never rises for that word. `in_rdy=1` after reset deasserts, and a subsequent word `8'hff` yields `out=8`.
- Instances `NBITS=100, CHUNK=100` (latency 1) and `NBITS=13, CHUNK=4` (`N_ITER=4`, `in_=13'h1fff` -> `out=13`): checked against a reference popcount over 20 random words each.
- With `ITER_POPCOUNT_ZEROS_EN` defined, `mode=1`, default params, `in_=1` -> `out=99`; `in_` all ones -> `out=0`.
